// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the fetch/data memory arbiter
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one single-port memory
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] cnt;

  logic        grant_d;
  logic        grant_any;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        gnt_we;

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    grant_any = if_req || d_req;
    grant_d   = d_req && (!if_req || (last_owner == OWN_I));
    gnt_addr  = grant_d ? d_addr : if_addr;
    gnt_we    = grant_d && d_we;
    gnt_wdata = grant_d ? d_wdata : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      d_rdata    <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_d ? OWN_D : OWN_I;
            last_owner <= grant_d ? OWN_D : OWN_I;
            cnt        <= '0;
            // Misaligned accesses never reach the memory.
            if (gnt_addr[1:0] != 2'b00) begin
              state <= RESP;
              if (grant_d) begin
                d_done  <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                if_done  <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= gnt_we;
              mem_addr  <= gnt_addr[31:2];
              mem_wdata <= gnt_wdata;
            end
          end
        end
        BUSY: begin
          if (mem_ack || (cnt == CNT_LAST)) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (owner == OWN_D) begin
              d_done <= 1'b1;
              d_err  <= !mem_ack;
              if (!mem_ack) d_rdata <= '0;
              else if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_err   <= !mem_ack;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
